// File: rtl/glip_uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: escape byte, message prefixes,
// FSM states and message types. The receive-side decoder uses the same values.
package glip_uart_tx_scheduler_pkg;

  localparam int unsigned CREDIT_WIDTH = 14;
  localparam logic [7:0]  ESCAPE        = 8'hFE;
  localparam logic [1:0]  PREFIX_CREDIT = 2'b10;
  localparam logic [1:0]  PREFIX_CTRL   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND0,
    ST_SEND1,
    ST_SEND2
  } state_e;

  typedef enum logic [1:0] {
    MSG_DATA,
    MSG_DATA_ESC,
    MSG_CREDIT,
    MSG_CTRL
  } msg_e;

  // Second byte of a multi-byte message; never ESCAPE except for escaped data.
  function automatic logic [7:0] second_byte(msg_e t, logic [CREDIT_WIDTH-1:0] p);
    logic [7:0] b;
    case (t)
      MSG_CREDIT: b = {PREFIX_CREDIT, p[13:8]};
      MSG_CTRL:   b = {PREFIX_CTRL, p[5:0]};
      default:    b = ESCAPE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/glip_uart_tx_scheduler_if.sv
// Requester, flow-control and transmitter signals of the UART TX scheduler.
// master = scheduler side, slave = surrounding FIFO/flow-control/UART side.
interface glip_uart_tx_scheduler_if;
  import glip_uart_tx_scheduler_pkg::*;

  logic [7:0]              egress_in_data;
  logic                    egress_in_valid;
  logic                    egress_in_ready;
  logic                    credit_valid;
  logic [CREDIT_WIDTH-1:0] credit_value;
  logic                    credit_ready;
  logic                    ctrl_valid;
  logic [5:0]              ctrl_code;
  logic                    ctrl_ready;
  logic                    tx_pause;
  logic [7:0]              tx_data;
  logic                    tx_enable;
  logic                    tx_done;
  logic                    busy;
  logic                    error;

  modport master (
    input  egress_in_data, egress_in_valid, credit_valid, credit_value,
           ctrl_valid, ctrl_code, tx_pause, tx_done,
    output egress_in_ready, credit_ready, ctrl_ready, tx_data, tx_enable,
           busy, error
  );

  modport slave (
    output egress_in_data, egress_in_valid, credit_valid, credit_value,
           ctrl_valid, ctrl_code, tx_pause, tx_done,
    input  egress_in_ready, credit_ready, ctrl_ready, tx_data, tx_enable,
           busy, error
  );

endinterface

// File: rtl/glip_uart_tx_scheduler.sv
// Arbitrates data/credit/ctrl requests onto one UART transmitter, emitting each
// grant as an escaped byte sequence over the tx_enable/tx_done handshake.
module glip_uart_tx_scheduler
  import glip_uart_tx_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  glip_uart_tx_scheduler_if.master  bus
);

  state_e                  state_q, state_d;
  msg_e                    msg_q, msg_d;
  logic [CREDIT_WIDTH-1:0] payload_q, payload_d;
  logic                    prefer_q, prefer_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_enable_q, tx_enable_d;
  logic                    error_q, error_d;
  logic                    grant_open, gnt_data, gnt_credit, gnt_ctrl;

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    payload_d   = payload_q;
    prefer_d    = prefer_q;
    tx_data_d   = tx_data_q;
    tx_enable_d = tx_enable_q;
    error_d     = error_q;

    // prefer_data forces one data slot after every non-data message.
    grant_open = (state_q == ST_IDLE) && !bus.tx_pause && !rst;
    gnt_data   = grant_open && bus.egress_in_valid &&
                 (prefer_q || !(bus.credit_valid || bus.ctrl_valid));
    gnt_credit = grant_open && bus.credit_valid && !gnt_data;
    gnt_ctrl   = grant_open && bus.ctrl_valid && !bus.credit_valid && !gnt_data;

    case (state_q)
      ST_IDLE: begin
        if (gnt_data) begin
          msg_d       = (bus.egress_in_data == ESCAPE) ? MSG_DATA_ESC : MSG_DATA;
          payload_d   = {6'b0, bus.egress_in_data};
          tx_data_d   = bus.egress_in_data;
          prefer_d    = 1'b0;
        end else if (gnt_credit) begin
          msg_d       = MSG_CREDIT;
          payload_d   = bus.credit_value;
          tx_data_d   = ESCAPE;
          prefer_d    = 1'b1;
        end else if (gnt_ctrl) begin
          msg_d       = MSG_CTRL;
          payload_d   = {8'b0, bus.ctrl_code};
          tx_data_d   = ESCAPE;
          prefer_d    = 1'b1;
        end
        if (gnt_data || gnt_credit || gnt_ctrl) begin
          state_d     = ST_SEND0;
          tx_enable_d = 1'b1;
        end
      end
      ST_SEND0: begin
        if (bus.tx_done) begin
          if (msg_q == MSG_DATA) begin
            state_d     = ST_IDLE;
            tx_enable_d = 1'b0;
          end else begin
            state_d     = ST_SEND1;
            tx_data_d   = second_byte(msg_q, payload_q);
          end
        end
      end
      ST_SEND1: begin
        if (bus.tx_done) begin
          if (msg_q == MSG_CREDIT) begin
            state_d     = ST_SEND2;
            tx_data_d   = payload_q[7:0];
          end else begin
            state_d     = ST_IDLE;
            tx_enable_d = 1'b0;
          end
        end
      end
      ST_SEND2: begin
        if (bus.tx_done) begin
          state_d     = ST_IDLE;
          tx_enable_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        tx_enable_d = 1'b0;
      end
    endcase

    if (bus.tx_done && !tx_enable_q) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      msg_q       <= MSG_DATA;
      payload_q   <= '0;
      prefer_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_enable_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      payload_q   <= payload_d;
      prefer_q    <= prefer_d;
      tx_data_q   <= tx_data_d;
      tx_enable_q <= tx_enable_d;
      error_q     <= error_d;
    end
  end

  assign bus.egress_in_ready = gnt_data;
  assign bus.credit_ready    = gnt_credit;
  assign bus.ctrl_ready      = gnt_ctrl;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_enable       = tx_enable_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.error           = error_q;

endmodule

// File: tb/tb_glip_uart_tx_scheduler.sv
// Scoreboard bench for glip_uart_tx_scheduler: a message-level model predicts
// grants and byte sequences; a negedge monitor compares them against the DUT.
module tb_glip_uart_tx_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  glip_uart_tx_scheduler_if bus ();

  glip_uart_tx_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] rdy;      // {ctrl, credit, egress}
    logic       busy;
    logic       en;
    logic       err;
    logic       chk_data;
    logic [7:0] data;
  } exp_cyc_t;

  exp_cyc_t   exp_q[$];
  logic [7:0] byte_q[$];
  int checks    = 0;
  int failures  = 0;
  int timeouts  = 0;

  // Message-level model state: bytes left in the current message.
  int m_rem     = 0;
  bit m_prefer  = 1'b0;
  bit m_err     = 1'b0;
  int last_kind = 0;   // 0 none, 1 data, 2 credit, 3 ctrl
  bit drain_chk = 1'b0;
  bit final_chk = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Inputs for this cycle are already driven: predict, push, advance the model.
  task automatic step();
    exp_cyc_t e;
    int kind;
    kind = 0;
    e = '0;
    if (rst) begin
      e.chk_data = 1'b1;
      e.data     = 8'h00;
    end else begin
      e.busy = (m_rem != 0);
      e.en   = (m_rem != 0);
      e.err  = m_err;
      if (m_rem == 0 && !bus.tx_pause) begin
        if (bus.egress_in_valid && m_prefer) kind = 1;
        else if (bus.credit_valid)           kind = 2;
        else if (bus.ctrl_valid)             kind = 3;
        else if (bus.egress_in_valid)        kind = 1;
      end
      if (kind != 0) e.rdy[kind-1] = 1'b1;
    end
    exp_q.push_back(e);

    if (rst) begin
      m_rem = 0; m_prefer = 1'b0; m_err = 1'b0;
    end else begin
      if (bus.tx_done) begin
        if (m_rem != 0) m_rem--;
        else m_err = 1'b1;
      end
      case (kind)
        1: begin
          if (bus.egress_in_data == 8'hFE) begin
            byte_q.push_back(8'hFE); byte_q.push_back(8'hFE); m_rem = 2;
          end else begin
            byte_q.push_back(bus.egress_in_data); m_rem = 1;
          end
          m_prefer = 1'b0;
        end
        2: begin
          byte_q.push_back(8'hFE);
          byte_q.push_back({2'b10, bus.credit_value[13:8]});
          byte_q.push_back(bus.credit_value[7:0]);
          m_rem = 3; m_prefer = 1'b1;
        end
        3: begin
          byte_q.push_back(8'hFE);
          byte_q.push_back({2'b00, bus.ctrl_code});
          m_rem = 2; m_prefer = 1'b1;
        end
        default: ;
      endcase
    end
    last_kind = kind;
    @(posedge clk);
    #1;
  endtask

  // Retire granted requests, optionally raise new ones, and play the transmitter.
  task automatic drive_random(input bit allow_new);
    if (last_kind == 1) bus.egress_in_valid = 1'b0;
    if (last_kind == 2) bus.credit_valid    = 1'b0;
    if (last_kind == 3) bus.ctrl_valid      = 1'b0;
    if (allow_new) begin
      if (!bus.egress_in_valid && $urandom_range(0, 3) == 0) begin
        bus.egress_in_valid = 1'b1;
        bus.egress_in_data  = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      end
      if (!bus.credit_valid && $urandom_range(0, 5) == 0) begin
        bus.credit_valid = 1'b1;
        bus.credit_value = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom);
      end
      if (!bus.ctrl_valid && $urandom_range(0, 5) == 0) begin
        bus.ctrl_valid = 1'b1;
        bus.ctrl_code  = 6'($urandom);
      end
      if ($urandom_range(0, 9) == 0) bus.tx_pause = ~bus.tx_pause;
    end
    bus.tx_done = (m_rem != 0) && ($urandom_range(0, 2) == 0);
  endtask

  task automatic run_until_quiet(input int bound);
    for (int i = 0; i < bound && (bus.egress_in_valid || bus.credit_valid ||
                                  bus.ctrl_valid || m_rem != 0); i++) begin
      drive_random(1'b0);
      step();
    end
    if (bus.egress_in_valid || bus.credit_valid || bus.ctrl_valid || m_rem != 0)
      timeouts++;
  endtask

  always @(negedge clk) begin
    exp_cyc_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("egress_in_ready", 16'(bus.egress_in_ready), 16'(e.rdy[0]));
      chk("credit_ready",    16'(bus.credit_ready),    16'(e.rdy[1]));
      chk("ctrl_ready",      16'(bus.ctrl_ready),      16'(e.rdy[2]));
      chk("busy",            16'(bus.busy),            16'(e.busy));
      chk("tx_enable",       16'(bus.tx_enable),       16'(e.en));
      chk("error",           16'(bus.error),           16'(e.err));
      if (e.chk_data) chk("tx_data_reset", 16'(bus.tx_data), 16'(e.data));
    end
    if (rst) begin
      byte_q.delete();
    end else if (bus.tx_enable) begin
      if (byte_q.size() == 0) begin
        chk("tx_enable_without_message", 16'(bus.tx_enable), 16'd0);
      end else begin
        chk("tx_data", 16'(bus.tx_data), 16'(byte_q[0]));
        if (bus.tx_done) void'(byte_q.pop_front());
      end
    end
    if (drain_chk) chk("bytes_left_after_drain", 16'(byte_q.size()), 16'd0);
    if (final_chk) chk("wait_bounds_expired", 16'(timeouts), 16'd0);
  end

  typedef struct { int kind; logic [13:0] val; } dir_t;
  dir_t dirs[$];

  initial begin
    rst = 1'b1;
    bus.egress_in_valid = 1'b0; bus.egress_in_data = 8'h00;
    bus.credit_valid = 1'b0; bus.credit_value = '0;
    bus.ctrl_valid = 1'b0; bus.ctrl_code = '0;
    bus.tx_pause = 1'b0; bus.tx_done = 1'b0;
    @(posedge clk); #1;

    // All three requesting during and out of reset: expect credit, data, ctrl.
    bus.credit_valid = 1'b1; bus.credit_value = 14'h0001;
    bus.ctrl_valid = 1'b1;   bus.ctrl_code = 6'h05;
    bus.egress_in_valid = 1'b1; bus.egress_in_data = 8'h10;
    step(); step();
    rst = 1'b0;
    run_until_quiet(80);

    dirs = '{'{1, 14'h0041}, '{1, 14'h00FE}, '{2, 14'h1234}, '{3, 14'h003F},
             '{2, 14'h3FFF}, '{2, 14'h0000}, '{1, 14'h00FF}, '{3, 14'h0000}};
    foreach (dirs[i]) begin
      case (dirs[i].kind)
        1: begin bus.egress_in_valid = 1'b1; bus.egress_in_data = dirs[i].val[7:0]; end
        2: begin bus.credit_valid = 1'b1; bus.credit_value = dirs[i].val; end
        default: begin bus.ctrl_valid = 1'b1; bus.ctrl_code = dirs[i].val[5:0]; end
      endcase
      run_until_quiet(40);
    end

    // Pause raised during the second credit byte; data waits until it drops.
    bus.credit_valid = 1'b1; bus.credit_value = 14'h2A5C;
    for (int i = 0; i < 20 && m_rem != 2; i++) begin drive_random(1'b0); step(); end
    if (m_rem != 2) timeouts++;
    bus.tx_pause = 1'b1;
    bus.egress_in_valid = 1'b1; bus.egress_in_data = 8'h5A;
    for (int i = 0; i < 40 && m_rem != 0; i++) begin drive_random(1'b0); step(); end
    if (m_rem != 0) timeouts++;
    for (int i = 0; i < 4; i++) begin drive_random(1'b0); step(); end
    bus.tx_pause = 1'b0;
    run_until_quiet(40);

    for (int i = 0; i < 3000; i++) begin drive_random(1'b1); step(); end
    bus.tx_pause = 1'b0;
    run_until_quiet(200);
    bus.tx_done = 1'b0;
    drain_chk = 1'b1; step(); drain_chk = 1'b0;

    // Reset in SEND1 of a ctrl message, then tx_done while idle.
    bus.ctrl_valid = 1'b1; bus.ctrl_code = 6'h05;
    for (int i = 0; i < 10 && m_rem == 0; i++) step();
    if (m_rem == 0) timeouts++;
    bus.ctrl_valid = 1'b0;
    bus.tx_done = 1'b1; step();
    bus.tx_done = 1'b0; step();
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
    bus.tx_done = 1'b1; step();
    bus.tx_done = 1'b0; step(); step(); step();
    rst = 1'b1; step();
    rst = 1'b0; step();

    final_chk = 1'b1;
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
